// File: rtl/iter_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with valid/ready channels.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow bypass CALC/FIX.
module iter_div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic              flush,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_result,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] ZERO     = {DATA_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic is_signed);
        if (is_signed && v[DATA_W-1]) begin
            magnitude = ZERO - v;
        end else begin
            magnitude = v;
        end
    endfunction

    state_t              state_r, state_nxt_s;
    logic [1:0]          op_r;
    logic [DATA_W-1:0]   a_r, b_mag_r, quo_r, rem_r, result_r;
    logic                sign_a_r, sign_b_r, div0_r, ovf_r;
    logic [CNT_W-1:0]    cnt_r;

    logic                accept_s, req_signed_s, req_div0_s, req_ovf_s, special_s;
    logic [DATA_W:0]     shift_s;
    logic                ge_s;
    logic [DATA_W-1:0]   sub_s, q_fix_s, r_fix_s, fix_res_s;
    logic                op_signed_s;

    // Request decode and special-case detection at the accept boundary.
    assign req_signed_s = ~req_op[0];
    assign req_div0_s   = (req_b == ZERO);
    assign req_ovf_s    = req_signed_s && (req_a == MIN_NEG) && (req_b == ALL_ONES);
    assign special_s    = req_div0_s | req_ovf_s;
    assign accept_s     = req_valid && (state_r == ST_IDLE) && !flush;

`ifdef DIV_EARLY_OUT_EN
    logic [DATA_W-1:0] special_res_s;
    assign special_res_s = req_op[1] ? (req_div0_s ? req_a : ZERO)
                                     : (req_div0_s ? ALL_ONES : MIN_NEG);
`endif

    // One restoring step; the partial remainder always stays below |B|, so DATA_W bits suffice.
    assign shift_s = {rem_r, quo_r[DATA_W-1]};
    assign ge_s    = (shift_s >= {1'b0, b_mag_r});
    assign sub_s   = shift_s[DATA_W-1:0] - b_mag_r;

    assign op_signed_s = ~op_r[0];
    assign q_fix_s     = (op_signed_s && (sign_a_r ^ sign_b_r)) ? (ZERO - quo_r) : quo_r;
    assign r_fix_s     = (op_signed_s && sign_a_r) ? (ZERO - rem_r) : rem_r;

    // Sign fix-up and special-case override, selecting quotient or remainder.
    always_comb begin
        fix_res_s = ZERO;
        if (div0_r) begin
            fix_res_s = op_r[1] ? a_r : ALL_ONES;
        end else if (ovf_r) begin
            fix_res_s = op_r[1] ? ZERO : MIN_NEG;
        end else begin
            fix_res_s = op_r[1] ? r_fix_s : q_fix_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
`ifdef DIV_EARLY_OUT_EN
                    state_nxt_s = special_s ? ST_DONE : ST_CALC;
`else
                    state_nxt_s = ST_CALC;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_FIX:  state_nxt_s = ST_DONE;
            ST_DONE: begin
                if (resp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
        if (flush) begin
            state_nxt_s = ST_IDLE;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // Output decode from the state register.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b0;
        case (state_r)
            ST_IDLE: req_ready = 1'b1;
            ST_CALC: busy = 1'b1;
            ST_FIX:  busy = 1'b1;
            ST_DONE: begin
                busy       = 1'b1;
                resp_valid = 1'b1;
            end
            default: req_ready = 1'b0;
        endcase
    end

    // Operand latch and iteration datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r     <= 2'b00;
            a_r      <= ZERO;
            b_mag_r  <= ZERO;
            quo_r    <= ZERO;
            rem_r    <= ZERO;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            div0_r   <= 1'b0;
            ovf_r    <= 1'b0;
            cnt_r    <= CNT_ZERO;
        end else if (accept_s) begin
            op_r     <= req_op;
            a_r      <= req_a;
            b_mag_r  <= magnitude(req_b, req_signed_s);
            quo_r    <= magnitude(req_a, req_signed_s);
            rem_r    <= ZERO;
            sign_a_r <= req_signed_s & req_a[DATA_W-1];
            sign_b_r <= req_signed_s & req_b[DATA_W-1];
            div0_r   <= req_div0_s;
            ovf_r    <= req_ovf_s;
            cnt_r    <= CNT_W'(DATA_W);
        end else if ((state_r == ST_CALC) && (cnt_r != CNT_ZERO)) begin
            rem_r <= ge_s ? sub_s : shift_s[DATA_W-1:0];
            quo_r <= {quo_r[DATA_W-2:0], ge_s};
            cnt_r <= cnt_r - CNT_W'(1);
        end
    end

    // Result register: written in FIX (or at accept on early-out), cleared by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= ZERO;
        end else if (flush) begin
            result_r <= ZERO;
        end else if (state_r == ST_FIX) begin
            result_r <= fix_res_s;
`ifdef DIV_EARLY_OUT_EN
        end else if (accept_s && special_s) begin
            result_r <= special_res_s;
`endif
        end
    end

    assign resp_result = result_r;

endmodule
